phase_sequencer: RTL and testbench

//   Parametrised N-phase sequencer with pause/restart control, per-phase dwell timing,
//   a loop counter and a one-shot mode. Drives the phase index and odd/even/terminal

---
 rtl/phase_sequencer_pkg.sv | 4 +
 rtl/phase_sequencer_if.sv | 26 ++
 rtl/phase_dwell_timer.sv | 25 ++
 rtl/phase_sequencer.sv | 73 +++++++
 tb/tb_phase_sequencer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared types for the phase sequencer: run/halt state encoding.
package phase_seq_pkg;
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} seq_state_t;
endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between a sequencer and the logic driving it.
interface phase_sequencer_if #(
    parameter int PHASE_W = 2,
    parameter int DWELL_W = 8,
    parameter int CNT_W   = 16
);
    logic               pause;
    logic               restart;
    logic               one_shot;
    logic [DWELL_W-1:0] dwell;
    logic [PHASE_W-1:0] phase;
    logic               odd;
    logic               even;
    logic               terminal;
    logic               done;
    logic [CNT_W-1:0]   pass_cnt;

    modport master (
        output pause, restart, one_shot, dwell,
        input  phase, odd, even, terminal, done, pass_cnt
    );
    modport slave (
        input  pause, restart, one_shot, dwell,
        output phase, odd, even, terminal, done, pass_cnt
    );
endinterface

// File: rtl/phase_dwell_timer.sv
// Per-phase dwell counter; expire compares against the live dwell value.
module phase_dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               clear,
    input  logic [DWELL_W-1:0] dwell,
    output logic               expire
);
    logic [DWELL_W-1:0] cnt;

    assign expire = (cnt >= dwell);

    // Counter saturates at the dwell value; the owner clears it on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (!hold && !expire)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/phase_sequencer.sv
// N-phase sequencer with dwell timing, pause/restart, pass counter and one-shot halt.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES = 3,
    parameter int PHASE_W    = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
    parameter int DWELL_W    = 8,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    phase_sequencer_if.slave sb
);
    generate
        if (NUM_PHASES < 1) begin : g_bad_phases
            $error("phase_sequencer: NUM_PHASES must be >= 1");
        end
    endgenerate

    localparam logic [PHASE_W-1:0] LAST = PHASE_W'(NUM_PHASES - 1);

    seq_state_t         state;
    logic [PHASE_W-1:0] phase_q;
    logic [CNT_W-1:0]   pass_q;
    logic               expire;
    logic               run;
    logic               last;
    logic               adv;

    assign run  = (state == RUN);
    assign last = (phase_q == LAST);
    assign adv  = run & ~sb.restart & ~sb.pause & expire;

    phase_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (sb.pause | ~run),
        .clear  (sb.restart | adv),
        .dwell  (sb.dwell),
        .expire (expire)
    );

    // A restart out of a running last phase still counts as a completed pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            pass_q  <= '0;
            state   <= RUN;
        end else if (sb.restart) begin
            phase_q <= '0;
            state   <= RUN;
            if (last && run)
                pass_q <= pass_q + 1'b1;
        end else if (adv) begin
            if (!last) begin
                phase_q <= phase_q + 1'b1;
            end else begin
                pass_q <= pass_q + 1'b1;
                if (sb.one_shot)
                    state <= HALT;
                else
                    phase_q <= '0;
            end
        end
    end

    assign sb.phase    = phase_q;
    assign sb.odd      = ~phase_q[0];
    assign sb.even     = phase_q[0];
    assign sb.terminal = last & run & (sb.restart | (~sb.pause & expire));
    assign sb.done     = (state == HALT);
    assign sb.pass_cnt = pass_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench: four sequencer configurations sharing one clock and reset.
module tb_phase_sequencer;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    phase_sequencer_if #(.PHASE_W(2), .DWELL_W(8), .CNT_W(16)) ia ();
    phase_sequencer_if #(.PHASE_W(2), .DWELL_W(8), .CNT_W(16)) ib ();
    phase_sequencer_if #(.PHASE_W(3), .DWELL_W(8), .CNT_W(2))  ic ();
    phase_sequencer_if #(.PHASE_W(1), .DWELL_W(8), .CNT_W(16)) id ();

    phase_sequencer #(.NUM_PHASES(3), .DWELL_W(8), .CNT_W(16)) ua (.clk(clk), .rst_n(rst_n), .sb(ia.slave));
    phase_sequencer #(.NUM_PHASES(4), .DWELL_W(8), .CNT_W(16)) ub (.clk(clk), .rst_n(rst_n), .sb(ib.slave));
    phase_sequencer #(.NUM_PHASES(5), .DWELL_W(8), .CNT_W(2))  uc (.clk(clk), .rst_n(rst_n), .sb(ic.slave));
    phase_sequencer #(.NUM_PHASES(1), .DWELL_W(8), .CNT_W(16)) ud (.clk(clk), .rst_n(rst_n), .sb(id.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ia.pause = 1'b1; ia.restart = 1'b0; ia.one_shot = 1'b0; ia.dwell = 8'd0;
        ib.pause = 1'b1; ib.restart = 1'b0; ib.one_shot = 1'b0; ib.dwell = 8'd0;
        ic.pause = 1'b1; ic.restart = 1'b0; ic.one_shot = 1'b0; ic.dwell = 8'd0;
        id.pause = 1'b1; id.restart = 1'b0; id.one_shot = 1'b0; id.dwell = 8'd0;
        #12 rst_n = 1'b1;
        tick();

        // reset state
        chk("rst_a_phase", ia.phase, 0);
        chk("rst_a_done", ia.done, 0);
        chk("rst_a_pass", ia.pass_cnt, 0);
        chk("rst_d_term", id.terminal, 0);

        // N=3, dwell=0 free run
        ia.pause = 1'b0; #1;
        chk("t1_p0", ia.phase, 0);
        chk("t1_p0_oe", {ia.odd, ia.even}, 2'b10);
        chk("t1_p0_term", ia.terminal, 0);
        tick();
        chk("t1_p1", ia.phase, 1);
        chk("t1_p1_oe", {ia.odd, ia.even}, 2'b01);
        chk("t1_p1_term", ia.terminal, 0);
        tick();
        chk("t1_p2", ia.phase, 2);
        chk("t1_p2_oe", {ia.odd, ia.even}, 2'b10);
        chk("t1_p2_term", ia.terminal, 1);
        tick();
        chk("t1_wrap", ia.phase, 0);
        chk("t1_pass", ia.pass_cnt, 1);
        ia.pause = 1'b1;

        // N=4, dwell=2, pause mid-phase 1
        ib.dwell = 8'd2; ib.pause = 1'b0;
        tick(); tick();
        chk("t2_p0_hold", ib.phase, 0);
        tick();
        chk("t2_p1", ib.phase, 1);
        tick();
        ib.pause = 1'b1;
        repeat (5) tick();
        chk("t2_paused", ib.phase, 1);
        chk("t2_paused_term", ib.terminal, 0);
        ib.pause = 1'b0;
        tick();
        chk("t2_resume1", ib.phase, 1);
        tick();
        chk("t2_p2", ib.phase, 2);
        ib.pause = 1'b1;

        // restart in last phase while paused
        ia.pause = 1'b0;
        tick(); tick();
        chk("t3_p2", ia.phase, 2);
        ia.pause = 1'b1; #1;
        chk("t3_pause_term", ia.terminal, 0);
        ia.restart = 1'b1; #1;
        chk("t3_rst_term", ia.terminal, 1);
        tick();
        ia.restart = 1'b0;
        chk("t3_phase", ia.phase, 0);
        chk("t3_pass", ia.pass_cnt, 2);

        // one-shot, dwell=1
        ia.one_shot = 1'b1; ia.dwell = 8'd1; ia.pause = 1'b0;
        repeat (5) tick();
        chk("t4_pre_phase", ia.phase, 2);
        chk("t4_pre_done", ia.done, 0);
        chk("t4_pre_term", ia.terminal, 1);
        tick();
        chk("t4_done", ia.done, 1);
        chk("t4_phase", ia.phase, 2);
        chk("t4_term", ia.terminal, 0);
        chk("t4_pass", ia.pass_cnt, 3);
        ia.pause = 1'b1; tick();
        ia.pause = 1'b0; ia.one_shot = 1'b0; tick();
        chk("t4_halt_done", ia.done, 1);
        chk("t4_halt_phase", ia.phase, 2);
        chk("t4_halt_pass", ia.pass_cnt, 3);
        ia.restart = 1'b1; #1;
        chk("t4_rst_term", ia.terminal, 0);
        tick();
        ia.restart = 1'b0; ia.pause = 1'b1;
        chk("t4_rst_phase", ia.phase, 0);
        chk("t4_rst_done", ia.done, 0);
        chk("t4_rst_pass", ia.pass_cnt, 3);

        // N=5: lowering dwell mid-phase, then pass counter wrap at CNT_W=2
        ic.dwell = 8'd10; ic.pause = 1'b0;
        repeat (6) tick();
        chk("t5_hold", ic.phase, 0);
        ic.dwell = 8'd3; #1;
        chk("t5_term", ic.terminal, 0);
        tick();
        chk("t5_adv", ic.phase, 1);
        ic.dwell = 8'd0;
        repeat (4) tick();
        chk("t5_pass1", ic.pass_cnt, 1);
        chk("t5_wrap_ph", ic.phase, 0);
        repeat (4) tick();
        chk("t5_p4_term", ic.terminal, 1);
        tick();
        chk("t5_pass2", ic.pass_cnt, 2);
        repeat (5) tick();
        chk("t5_pass3", ic.pass_cnt, 3);
        repeat (5) tick();
        chk("t5_pass_wrap", ic.pass_cnt, 0);
        ic.pause = 1'b1;

        // N=1, dwell=2
        id.dwell = 8'd2; id.pause = 1'b0;
        tick(); tick();
        chk("t6_n1_pass0", id.pass_cnt, 0);
        chk("t6_n1_term", id.terminal, 1);
        tick();
        chk("t6_n1_pass1", id.pass_cnt, 1);
        chk("t6_n1_phase", id.phase, 0);
        chk("t6_n1_term0", id.terminal, 0);
        repeat (3) tick();
        chk("t6_n1_pass2", id.pass_cnt, 2);
        id.one_shot = 1'b1;
        repeat (3) tick();
        chk("t6_n1_done", id.done, 1);
        chk("t6_n1_pass3", id.pass_cnt, 3);
        tick();
        chk("t6_n1_halt", id.pass_cnt, 3);

        // async reset mid-phase 3 of the N=4 instance
        ib.pause = 1'b0;
        repeat (4) tick();
        chk("t6_b_p3", ib.phase, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_b_phase", ib.phase, 0);
        chk("t6_async_b_oe", {ib.odd, ib.even}, 2'b10);
        chk("t6_async_a_pass", ia.pass_cnt, 0);
        chk("t6_async_d_done", id.done, 0);
        chk("t6_async_d_pass", id.pass_cnt, 0);
        #20 rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
